// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control sequencer for the MIPS core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with variable-latency memories, counts retirements.
module mips_multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t      cur;
    logic [31:0] wait_cnt;

    logic is_load;
    logic is_store;
    logic is_sys;
    logic is_nowb;
    logic is_regw;
    logic is_illegal;
    logic timeout;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sys   = 1'b0;
        is_nowb  = 1'b0;
        is_regw  = 1'b0;
        case (opcode)
            6'h00: begin
                if (func == 6'h0C)      is_sys  = 1'b1;
                else if (func == 6'h08) is_nowb = 1'b1;
                else                    is_regw = 1'b1;
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: is_nowb = 1'b1;
            6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:        is_regw = 1'b1;
            6'h20, 6'h23, 6'h24:               is_load = 1'b1;
            6'h28, 6'h2B:                      is_store = 1'b1;
            default: ;
        endcase
        is_illegal = ~(is_load | is_store | is_sys | is_nowb | is_regw);
    end

    // Timeout fires on the MEM_TIMEOUT-th consecutive non-ready cycle; ready wins ties.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1));

    // Reset forces FETCH asynchronously, so state-decoded outputs follow without a clock.
    // ir_we is Mealy on imem_ready and is gated by reset explicitly.
    always_comb begin
        imem_req = (cur == S_FETCH);
        ir_we    = (cur == S_FETCH) && imem_ready && !rst_b;
        dmem_req = (cur == S_MEM);
        dmem_we  = (cur == S_MEM) && is_store;
        reg_we   = (cur == S_WB);
        pc_we    = ((cur == S_EXEC) && is_nowb) ||
                   ((cur == S_MEM) && is_store && dmem_ready) ||
                   (cur == S_WB);
        halted   = (cur == S_HALT) || (cur == S_FAULT);
        fault    = (cur == S_FAULT);
        state    = cur;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            if (pc_we) instret <= instret + CNT_W'(1);
            wait_cnt <= '0;
            case (cur)
                S_FETCH: begin
                    if (imem_ready)   cur <= S_DECODE;
                    else if (timeout) cur <= S_FAULT;
                    else              wait_cnt <= wait_cnt + 32'd1;
                end
                S_DECODE: begin
                    if (is_sys)          cur <= S_HALT;
                    else if (is_illegal) cur <= S_FAULT;
                    else                 cur <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_load || is_store) cur <= S_MEM;
                    else if (is_regw)        cur <= S_WB;
                    else                     cur <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready)   cur <= is_store ? S_FETCH : S_WB;
                    else if (timeout) cur <= S_FAULT;
                    else              wait_cnt <= wait_cnt + 32'd1;
                end
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                S_FAULT: cur <= S_FAULT;
                default: cur <= S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Randomised scoreboard bench for mips_multicycle_sequencer: each issued instruction
// pushes its expected cycle count and enable activity; a monitor pops on retire/halt.
module tb_mips_multicycle_sequencer;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_we, pc_we, dmem_req, dmem_we, reg_we, halted, fault;
    logic [2:0]  state;
    logic [31:0] instret;

    mips_multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .halted(halted), .fault(fault), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        int     cycles;
        int     regw;
        int     dwe;
        int     dreq;
        int     irw;
        bit     term;
        int     st;
        int     flt;
        longint icount;
    } exp_t;

    exp_t   exp_q[$];
    int     n_total = 0;
    int     n_pass  = 0;
    bit     mon_en  = 1'b0;
    longint model_ret = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    int cyc, a_reg, a_dwe, a_dreq, a_ir;
    bit halt_seen;

    task automatic pop_and_compare(input bit is_halt);
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL exp_q_empty: got output event with no expectation (t=%0t)", $time);
            return;
        end
        n_pass++;
        e = exp_q.pop_front();
        check("cycles", cyc, e.cycles);
        check("reg_we_cnt", a_reg, e.regw);
        check("dmem_we_cnt", a_dwe, e.dwe);
        check("dmem_req_cnt", a_dreq, e.dreq);
        check("ir_we_cnt", a_ir, e.irw);
        check("terminal", is_halt, e.term);
        check("instret", instret, e.icount);
        if (is_halt) begin
            check("term_state", state, e.st);
            check("fault", fault, e.flt);
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            cyc = 0; a_reg = 0; a_dwe = 0; a_dreq = 0; a_ir = 0; halt_seen = 0;
        end else begin
            cyc++;
            a_reg  += int'(reg_we);
            a_dwe  += int'(dmem_we);
            a_dreq += int'(dmem_req);
            a_ir   += int'(ir_we);
            check("we_excl", reg_we & dmem_we, 0);
            check("pc_ir_excl", pc_we & ir_we, 0);
            check("dwe_without_req", dmem_we & ~dmem_req, 0);
            if (halted) begin
                if (!halt_seen) begin
                    halt_seen = 1;
                    pop_and_compare(1);
                end else begin
                    check("term_quiet", {pc_we, ir_we, reg_we, dmem_req, dmem_we}, 0);
                end
            end else if (pc_we) begin
                pop_and_compare(0);
                cyc = 0; a_reg = 0; a_dwe = 0; a_dreq = 0; a_ir = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam int C_LOAD = 0, C_STORE = 1, C_NOWB = 2, C_REGW = 3, C_SYS = 4, C_ILL = 5;

    logic [5:0] load_ops[3]  = '{6'h20, 6'h23, 6'h24};
    logic [5:0] store_ops[2] = '{6'h28, 6'h2B};
    logic [5:0] nowb_ops[5]  = '{6'h02, 6'h04, 6'h05, 6'h06, 6'h07};
    logic [5:0] regi_ops[9]  = '{6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] ill_ops[14]  = '{6'h01, 6'h10, 6'h1C, 6'h21, 6'h22, 6'h25, 6'h26,
                                 6'h27, 6'h29, 6'h2A, 6'h2C, 6'h2E, 6'h30, 6'h3F};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        rst_b = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_enables", {ir_we, pc_we, reg_we, dmem_req, dmem_we, halted, fault}, 0);
        check("rst_instret", instret, 0);
        rst_b = 1'b0;
        exp_q.delete();
        model_ret = 0;
        #1;
        check("post_rst_imem_req", imem_req, 1);
        check("post_rst_state", state, 0);
        mon_en = 1'b1;
    endtask

    // Issue one instruction of class cls; iwait/dwait are the non-ready cycles before ready.
    task automatic run_instr(input int cls, input logic [5:0] op, input logic [5:0] fn,
                             input int iwait, input int dwait);
        exp_t e;
        bit   has_mem = (cls == C_LOAD) || (cls == C_STORE);
        bit   f_to    = (iwait >= TMO);
        bit   m_to    = has_mem && (dwait >= TMO) && !f_to;
        int   ms      = iwait + 3;
        int   len;
        e = '{cycles: 0, regw: 0, dwe: 0, dreq: 0, irw: 1, term: 0, st: 0, flt: 0,
              icount: model_ret};
        if (f_to) begin
            e.cycles = TMO + 1; e.irw = 0; e.term = 1; e.st = 6; e.flt = 1;
        end else if (cls == C_SYS || cls == C_ILL) begin
            e.cycles = iwait + 3; e.term = 1;
            e.st = (cls == C_SYS) ? 5 : 6;
            e.flt = (cls == C_SYS) ? 0 : 1;
        end else if (m_to) begin
            e.cycles = iwait + 3 + TMO + 1; e.term = 1; e.st = 6; e.flt = 1;
            e.dreq = TMO; e.dwe = (cls == C_STORE) ? TMO : 0;
        end else begin
            case (cls)
                C_NOWB:  e.cycles = iwait + 3;
                C_REGW:  begin e.cycles = iwait + 4; e.regw = 1; end
                C_STORE: begin e.cycles = iwait + dwait + 4; e.dreq = dwait + 1; e.dwe = dwait + 1; end
                default: begin e.cycles = iwait + dwait + 5; e.dreq = dwait + 1; e.regw = 1; end
            endcase
            model_ret++;
        end
        exp_q.push_back(e);
        len = e.term ? e.cycles + 4 : e.cycles;
        opcode = op;
        func   = fn;
        for (int c = 0; c < len; c++) begin
            if (c <= iwait) imem_ready = !f_to && (c == iwait);
            else            imem_ready = rbit();
            if (has_mem && !f_to && c >= ms && c <= ms + dwait) dmem_ready = !m_to && (c == ms + dwait);
            else                                                dmem_ready = rbit();
            @(posedge clk);
            #1;
        end
        if (e.term) do_reset();
    endtask

    task automatic run_random();
        int r = $urandom_range(0, 19);
        int cls;
        logic [5:0] op;
        logic [5:0] fn = 6'($urandom_range(0, 63));
        if (r == 0)      cls = C_SYS;
        else if (r == 1) cls = C_ILL;
        else             cls = $urandom_range(C_LOAD, C_REGW);
        case (cls)
            C_LOAD:  op = load_ops[$urandom_range(0, 2)];
            C_STORE: op = store_ops[$urandom_range(0, 1)];
            C_NOWB: begin
                if (rbit()) begin op = 6'h00; fn = 6'h08; end
                else op = nowb_ops[$urandom_range(0, 4)];
            end
            C_REGW: begin
                if (rbit()) begin
                    op = 6'h00;
                    while (fn == 6'h08 || fn == 6'h0C) fn = 6'($urandom_range(0, 63));
                end else op = regi_ops[$urandom_range(0, 8)];
            end
            C_SYS: begin op = 6'h00; fn = 6'h0C; end
            default: op = ill_ops[$urandom_range(0, 13)];
        endcase
        run_instr(cls, op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        do_reset();
        run_instr(C_REGW, 6'h00, 6'h20, 0, 0);   // add
        run_instr(C_LOAD, 6'h23, 6'h00, 0, 3);   // lw with slow dmem
        run_instr(C_STORE, 6'h2B, 6'h00, 0, 0);  // sw
        run_instr(C_NOWB, 6'h04, 6'h00, 0, 0);   // beq
        run_instr(C_REGW, 6'h08, 6'h00, 14, 0);  // ready on the last allowed fetch cycle
        run_instr(C_STORE, 6'h28, 6'h00, 1, 14); // ready on the last allowed mem cycle
        run_instr(C_REGW, 6'h00, 6'h20, 15, 0);  // fetch timeout
        run_instr(C_NOWB, 6'h02, 6'h00, 0, 0);
        run_instr(C_SYS, 6'h00, 6'h0C, 0, 0);    // syscall
        run_instr(C_ILL, 6'h3F, 6'h00, 0, 0);    // illegal
        run_instr(C_LOAD, 6'h20, 6'h00, 0, 15);  // dmem timeout

        // Reset while in MEM: request must drop without a clock edge.
        run_instr(C_REGW, 6'h0D, 6'h00, 0, 0);
        run_instr(C_NOWB, 6'h00, 6'h08, 0, 0);
        opcode = 6'h23;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            imem_ready = 1'b0;
        end
        check("mid_mem_req", dmem_req, 1);
        check("mid_mem_instret", instret, 2);
        mon_en = 1'b0;
        #2;
        rst_b = 1'b1;
        #1;
        check("async_dmem_req_drop", dmem_req, 0);
        check("async_state", state, 0);
        check("async_instret", instret, 0);
        do_reset();

        for (int i = 0; i < 150; i++) run_random();

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        check("drain_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_sequencer.md
# mips_multicycle_sequencer

Multi-cycle control sequencer for the MIPS core datapath. It steps each instruction through fetch, decode, execute, memory and write-back phases, and drives the datapath's enables: PC write, IR load, register write, and data-memory request/write. It handshakes with variable-latency instruction and data memories, detects `syscall` and illegal opcodes, and counts retired instructions. It sits beside the combinational decode controller and gates that controller's register and memory write intents.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive wait cycles for a memory ready; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst_b`, in, 1: reset; asynchronous and active-high (despite the suffix).
- `opcode`, in, 6: IR[31:26].
- `func`, in, 6: IR[5:0].
- `imem_ready`, in, 1: instruction word valid this cycle.
- `dmem_ready`, in, 1: data access complete this cycle.
- `imem_req`, out, 1: instruction fetch request.
- `ir_we`, out, 1: load the IR.
- `pc_we`, out, 1: update the PC (final cycle of each instruction).
- `dmem_req`, out, 1: data memory request.
- `dmem_we`, out, 1: data memory write; only asserted with `dmem_req`.
- `reg_we`, out, 1: register file write.
- `halted`, out, 1: core stopped (HALT or FAULT).
- `fault`, out, 1: stopped by timeout or illegal opcode.
- `state`, out, 3: current state encoding, for debug.
- `instret`, out, `CNT_W`: retired-instruction count.

## Operation

State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.

**Reset.** Reset forces FETCH, `wait_cnt`=0 and `instret`=0.
- With reset asserted, all outputs except `imem_req` are 0; `state` reads 0.
- `imem_req` is 1 as soon as reset deasserts (it is asserted throughout FETCH).

**Decode classes**, evaluated from `opcode`/`func`:
- load: 0x20 lb, 0x23 lw, 0x24 lbu.
- store: 0x28 sb, 0x2B sw.
- syscall: opcode 0x00 with func 0x0C.
- no-writeback: 0x02 j, 0x04–0x07 branches, and opcode 0x00 with func 0x08 (jr).
- regwrite: all other opcode-0x00 R-type, 0x03 jal, and 0x08–0x0F immediate ALU ops.
- illegal: everything else.

**State transitions:**
- **FETCH**:
  - `imem_req`=1.
  - If `imem_ready`: `ir_we`=1 (Mealy), go to DECODE.
  - Else if timeout is reached: go to FAULT.
- **DECODE**:
  - syscall: go to HALT.
  - illegal: go to FAULT.
  - otherwise: go to EXEC.
- **EXEC**:
  - load/store: go to MEM.
  - regwrite: go to WB.
  - no-writeback: `pc_we`=1, go to FETCH.
- **MEM**:
  - `dmem_req`=1; `dmem_we`=1 for stores.
  - If `dmem_ready` and store: `pc_we`=1 (Mealy), go to FETCH.
  - If `dmem_ready` and load: go to WB.
  - Else if timeout is reached: go to FAULT.
- **WB**: `reg_we`=1, `pc_we`=1, go to FETCH.
- **HALT**: terminal until reset. `halted`=1, `fault`=0.
- **FAULT**: terminal until reset. `halted`=1, `fault`=1.

**Outputs in terminal states.** HALT and FAULT assert no other enables. `pc_we` stays 0, so the PC holds the address of the stopping instruction.

**Retired-instruction counter.** `instret` increments on every edge where `pc_we`=1. It wraps modulo 2^`CNT_W`.

## Timing

**Wait counter and timeout.**
- `wait_cnt` clears on entry to FETCH or MEM.
- It increments on each cycle spent in FETCH or MEM with the relevant ready low.
- Timeout is reached when ready is low and `wait_cnt`==`MEM_TIMEOUT`-1, so FAULT follows exactly `MEM_TIMEOUT` non-ready cycles.
- Ready arriving in that same cycle takes priority: no fault.
- With `MEM_TIMEOUT`=0, waits are unbounded.

**Cycles per instruction, with zero-wait memories:**
- no-writeback: 3 (FETCH, DECODE, EXEC).
- regwrite: 4.
- store: 4.
- load: 5.
- Each memory wait cycle adds 1.

**Mealy outputs.** `ir_we` and the store-completion `pc_we` depend combinationally on ready. All other outputs decode from state only.

**Ready inputs.** `imem_ready` is ignored outside FETCH and `dmem_ready` is ignored outside MEM; neither is latched.

**Reset mid-operation.** Asserting `rst_b` aborts any phase immediately: outputs go to their reset values without waiting for a clock, any pending memory request is dropped, and `instret` clears.

**Write-enable exclusivity.** At most one of `reg_we`/`dmem_we` is high in any cycle. `pc_we` and `ir_we` are never high together.

## Test plan
- **add, zero-wait memory.** Reset, then `opcode`=0x00, `func`=0x20, both readies held high → states 0,1,2,4,0; `reg_we` and `pc_we` high in cycle 4; `instret`=1.
- **lw with slow data memory.** `opcode`=0x23, `dmem_ready` low for 3 cycles → MEM lasts 4 cycles with `dmem_we`=0; then WB with `reg_we`=1; 8 cycles total; `instret`+1.
- **sw then beq.** sw (0x2B) → `dmem_req`=`dmem_we`=1, `pc_we` in the ready cycle, no `reg_we`. Then beq (0x04) → `pc_we` in EXEC, 3 cycles, no `reg_we`.
- **Fetch timeout.** `MEM_TIMEOUT`=15 and `imem_ready` low for 15 cycles → `state`=6, `halted`=`fault`=1. Separate run: ready arrives on the 15th cycle → no fault.
- **syscall and illegal opcode.** syscall (0x00/0x0C) → `state`=5, `halted`=1, `fault`=0, `pc_we` never pulses, `instret` unchanged. `opcode`=0x3F → `state`=6, `fault`=1.
- **Reset mid-MEM.** Assert `rst_b` asynchronously mid-cycle while in MEM → `dmem_req` drops without waiting for a clock edge, `instret`=0; after release, `state`=0 and `imem_req`=1.
